// File: rtl/punc_debug_snapshot.sv
// rtl/punc_debug_snapshot.sv - walks PUnC PC, R0-R7 and a memory window over the debug ports
// and streams each sampled word out over a valid/ready link.
module punc_debug_snapshot #(
  parameter logic [15:0] MEM_BASE  = 16'h0000,
  parameter int          MEM_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] mem_debug_addr,
  output logic [2:0]  rf_debug_addr,
  input  logic [15:0] mem_debug_data,
  input  logic [15:0] rf_debug_data,
  input  logic [15:0] pc_debug_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [1:0]  out_tag,
  output logic        out_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SAMPLE,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [16:0] LAST_IDX = 17'(8 + MEM_WORDS);

  state_t      state;
  state_t      state_next;
  logic [16:0] index;
  logic [16:0] adv_index;
  logic [15:0] adv_mem_off;
  logic        handshake;
  logic [1:0]  cur_tag;
  logic [15:0] cur_data;

  assign handshake   = out_valid && out_ready;
  assign adv_index   = index + 17'd1;
  assign adv_mem_off = adv_index[15:0] - 16'd9;
  assign busy        = (state == S_ISSUE) || (state == S_SAMPLE) || (state == S_SEND);
  assign done        = (state == S_DONE);

  // Item 0 is the PC, items 1..8 are R0..R7, everything after is memory.
  always_comb begin
    cur_tag  = 2'd2;
    cur_data = mem_debug_data;
    if (index == 17'd0) begin
      cur_tag  = 2'd0;
      cur_data = pc_debug_data;
    end else if (index <= 17'd8) begin
      cur_tag  = 2'd1;
      cur_data = rf_debug_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_ISSUE;
      S_ISSUE:  state_next = S_SAMPLE;
      S_SAMPLE: state_next = S_SEND;
      S_SEND: begin
        if (handshake) begin
          state_next = out_last ? S_DONE : S_ISSUE;
        end
      end
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Addresses are loaded on entry to ISSUE so they are stable through ISSUE and
  // SAMPLE, which covers both combinational and one-cycle-registered debug reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      index          <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_tag        <= '0;
      out_last       <= 1'b0;
      mem_debug_addr <= '0;
      rf_debug_addr  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) index <= '0;
        end
        S_SAMPLE: begin
          out_data  <= cur_data;
          out_tag   <= cur_tag;
          out_last  <= (index == LAST_IDX);
          out_valid <= 1'b1;
        end
        S_SEND: begin
          if (handshake) begin
            out_valid <= 1'b0;
            if (!out_last) begin
              index <= adv_index;
              if (adv_index <= 17'd8) begin
                rf_debug_addr <= adv_index[2:0] - 3'd1;
              end else begin
                mem_debug_addr <= MEM_BASE + adv_mem_off;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_punc_debug_snapshot.sv
// tb/tb_punc_debug_snapshot.sv - directed bench for punc_debug_snapshot.
module tb_punc_debug_snapshot;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic [15:0] glitch = 16'h0000;
  int sel = 0;

  logic        busy_s  [3];
  logic        done_s  [3];
  logic [15:0] ma_s    [3];
  logic [2:0]  ra_s    [3];
  logic [15:0] md_s    [3];
  logic [15:0] rd_s    [3];
  logic        v_s     [3];
  logic [15:0] d_s     [3];
  logic [1:0]  t_s     [3];
  logic        l_s     [3];
  logic        start_s [3];
  logic [15:0] pc_val;

  always #5 clk = ~clk;

  assign pc_val = 16'h3000 + glitch;
  assign md_s[0] = 16'hA000 + (ma_s[0] - 16'h3000) + glitch;
  assign md_s[1] = (ma_s[1] ^ 16'h5A5A) + glitch;
  assign md_s[2] = 16'hEEEE + glitch;
  assign rd_s[0] = 16'h0010 + {13'b0, ra_s[0]} + glitch;
  assign rd_s[1] = 16'h0010 + {13'b0, ra_s[1]} + glitch;
  assign rd_s[2] = 16'h0010 + {13'b0, ra_s[2]} + glitch;
  assign start_s[0] = start && (sel == 0);
  assign start_s[1] = start && (sel == 1);
  assign start_s[2] = start && (sel == 2);

  punc_debug_snapshot #(.MEM_BASE(16'h3000), .MEM_WORDS(4)) u_a (
    .clk(clk), .rst(rst), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .mem_debug_addr(ma_s[0]), .rf_debug_addr(ra_s[0]), .mem_debug_data(md_s[0]),
    .rf_debug_data(rd_s[0]), .pc_debug_data(pc_val), .out_valid(v_s[0]),
    .out_ready(ready), .out_data(d_s[0]), .out_tag(t_s[0]), .out_last(l_s[0]));

  punc_debug_snapshot #(.MEM_BASE(16'hFFFE), .MEM_WORDS(4)) u_b (
    .clk(clk), .rst(rst), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .mem_debug_addr(ma_s[1]), .rf_debug_addr(ra_s[1]), .mem_debug_data(md_s[1]),
    .rf_debug_data(rd_s[1]), .pc_debug_data(pc_val), .out_valid(v_s[1]),
    .out_ready(ready), .out_data(d_s[1]), .out_tag(t_s[1]), .out_last(l_s[1]));

  punc_debug_snapshot #(.MEM_BASE(16'h0000), .MEM_WORDS(0)) u_c (
    .clk(clk), .rst(rst), .start(start_s[2]), .busy(busy_s[2]), .done(done_s[2]),
    .mem_debug_addr(ma_s[2]), .rf_debug_addr(ra_s[2]), .mem_debug_data(md_s[2]),
    .rf_debug_data(rd_s[2]), .pc_debug_data(pc_val), .out_valid(v_s[2]),
    .out_ready(ready), .out_data(d_s[2]), .out_tag(t_s[2]), .out_last(l_s[2]));

  logic        v, l, b, dn;
  logic [15:0] d, ma;
  logic [1:0]  t;
  logic [2:0]  ra;
  assign v  = v_s[sel];
  assign l  = l_s[sel];
  assign b  = busy_s[sel];
  assign dn = done_s[sel];
  assign d  = d_s[sel];
  assign t  = t_s[sel];
  assign ma = ma_s[sel];
  assign ra = ra_s[sel];

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  int nrecv, done_cyc, ndone, first_v_cyc, unstable, extra_v;
  logic busy1, busy_at_done, busy_end;
  logic [15:0] got_d  [32];
  logic [1:0]  got_t  [32];
  logic        got_l  [32];
  logic [15:0] got_ma [32];
  logic [15:0] wexp   [4];
  logic [15:0] waddr  [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic collect(input int stall, input int restart_word);
    int cyc, hold, end_cyc;
    logic restarted;
    logic [15:0] cd;
    logic [1:0] ct;
    for (int i = 0; i < 32; i++) begin
      got_d[i] = 'x; got_t[i] = 'x; got_l[i] = 'x; got_ma[i] = 'x;
    end
    nrecv = 0; done_cyc = -1; ndone = 0; first_v_cyc = -1; unstable = 0; extra_v = 0;
    busy1 = 1'b0; busy_at_done = 1'bx; cd = '0; ct = '0;
    ready = (stall == 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1; end_cyc = 3000; hold = 0; restarted = 1'b0;
    while (cyc < end_cyc) begin
      if (cyc == 1) busy1 = b;
      if (v && first_v_cyc < 0) first_v_cyc = cyc;
      if (dn) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = cyc; busy_at_done = b; end_cyc = cyc + 10;
        end
      end else if (done_cyc >= 0 && v) begin
        extra_v++;
      end
      start = (restart_word >= 0) && !restarted && v && (nrecv == restart_word);
      if (start) restarted = 1'b1;
      if (v) begin
        if (hold == 0) begin cd = d; ct = t; end
        else if (d !== cd || t !== ct) unstable++;
        if (hold < stall) begin
          ready = 1'b0; glitch = 16'h0F00; hold++;
        end else begin
          ready = 1'b1; glitch = 16'h0000; hold = 0;
          if (nrecv < 32) begin
            got_d[nrecv] = d; got_t[nrecv] = t; got_l[nrecv] = l; got_ma[nrecv] = ma;
          end
          nrecv++;
        end
      end else begin
        ready = (stall == 0); glitch = 16'h0000;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    busy_end = b;
  endtask

  task automatic check_words(input string pre, input int n, input int mode);
    chk({pre, "_count"}, nrecv, n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] ed;
      logic [1:0]  et;
      if (i == 0) begin
        ed = 16'h3000; et = 2'd0;
      end else if (i <= 8) begin
        ed = 16'h000F + 16'(i); et = 2'd1;
      end else begin
        et = 2'd2;
        ed = (mode == 0) ? 16'hA000 + 16'(i - 9) : wexp[i - 9];
        if (mode == 1) chk($sformatf("%s_addr%0d", pre, i), got_ma[i], waddr[i - 9]);
      end
      chk($sformatf("%s_data%0d", pre, i), got_d[i], ed);
      chk($sformatf("%s_tag%0d", pre, i), got_t[i], et);
      chk($sformatf("%s_last%0d", pre, i), got_l[i], (i == n - 1));
    end
  endtask

  initial begin
    int cnt;
    wexp[0] = 16'hA5A4; wexp[1] = 16'hA5A5; wexp[2] = 16'h5A5A; wexp[3] = 16'h5A5B;
    waddr[0] = 16'hFFFE; waddr[1] = 16'hFFFF; waddr[2] = 16'h0000; waddr[3] = 16'h0001;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", b, 0);
    chk("rst_done", dn, 0);
    chk("rst_valid", v, 0);
    chk("rst_data", d, 0);
    chk("rst_tag", t, 0);
    chk("rst_last", l, 0);
    chk("rst_maddr", ma, 0);
    chk("rst_raddr", ra, 0);
    rst = 1'b0;

    // Full dump with ready held high.
    sel = 0;
    collect(0, -1);
    check_words("full", 13, 0);
    chk("full_busy1", busy1, 1);
    chk("full_first_valid", first_v_cyc, 3);
    chk("full_done_cyc", done_cyc, 40);
    chk("full_ndone", ndone, 1);
    chk("full_busy_at_done", busy_at_done, 0);

    // Backpressure: five stalled cycles per word with debug data disturbed meanwhile.
    collect(5, -1);
    check_words("bp", 13, 0);
    chk("bp_stable", unstable, 0);
    chk("bp_done_cyc", done_cyc, 105);
    chk("bp_ndone", ndone, 1);

    // Second start during word 3 must be ignored.
    collect(0, 3);
    check_words("rs", 13, 0);
    chk("rs_ndone", ndone, 1);
    chk("rs_extra_valid", extra_v, 0);
    chk("rs_busy_after", busy_end, 0);

    // Reset during the SEND of word 6 (R5).
    ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 200 && cnt < 7; c++) begin
      if (v) begin
        if (cnt == 6) begin
          chk("mr_pre_raddr", ra, 5);
          ready = 1'b0; rst = 1'b1; cnt = 7;
        end else begin
          cnt++;
        end
      end
      if (cnt < 7) @(negedge clk);
    end
    chk("mr_reached", cnt, 7);
    @(negedge clk);
    rst = 1'b0;
    chk("mr_valid", v, 0);
    chk("mr_busy", b, 0);
    chk("mr_done", dn, 0);
    chk("mr_maddr", ma, 0);
    chk("mr_raddr", ra, 0);
    collect(0, -1);
    check_words("mr", 13, 0);
    chk("mr_done_cyc", done_cyc, 40);

    // Memory window wrapping past FFFF.
    sel = 1;
    collect(0, -1);
    check_words("wrap", 13, 1);
    chk("wrap_ndone", ndone, 1);

    // Empty memory section.
    sel = 2;
    collect(0, -1);
    check_words("empty", 9, 0);
    chk("empty_done_cyc", done_cyc, 28);
    chk("empty_ndone", ndone, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
